// File: rtl/bram_sp_cfg_if.sv
// Access/status bundle for the configurable single-port block RAM.
// The master side drives the access; the RAM is the slave.
interface bram_sp_cfg_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BYTE_WIDTH = 8
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  en_a;
  logic [NUM_BYTES-1:0]  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic                  clr_req;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  dout_valid_a;
  logic                  busy;

  modport master (
    output en_a, we_a, addr_a, din_a, clr_req,
    input  dout_a, dout_valid_a, busy
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a, clr_req,
    output dout_a, dout_valid_a, busy
  );
endinterface

// File: rtl/bram_sp_cfg.sv
// Single-port block RAM with byte enables, selectable read-during-write mode,
// optional output register, read-valid strobe and a hardware clear sweep.
module bram_sp_cfg #(
  parameter int unsigned            ADDR_WIDTH = 10,
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            BYTE_WIDTH = 8,
  parameter int unsigned            RD_MODE    = 0,
  parameter int unsigned            OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0]  CLR_VAL    = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  bram_sp_cfg_if.slave  bus
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q;
  logic                  clr_wr_c, acc_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_c, merged_c;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  v1_q, v1_d;

  // State register, clear counter and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_CLEAR);
    end
  end

  // Next-state: sweep every address once, then idle until a clear request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = ADDR_WIDTH'(cnt_q + 1'b1);
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // FSM outputs: the clear request cycle still performs the user access
  always_comb begin
    clr_wr_c = 1'b0;
    acc_c    = 1'b0;
    case (state_q)
      S_CLEAR: clr_wr_c = 1'b1;
      S_IDLE:  acc_c    = bus.en_a;
      default: clr_wr_c = 1'b0;
    endcase
  end

  assign old_c = mem[bus.addr_a];

  always_comb begin
    merged_c = old_c;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      if (bus.we_a[i]) merged_c[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_wr_c) begin
      mem[cnt_q] <= CLR_VAL;
    end else if (acc_c) begin
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
        if (bus.we_a[i]) mem[bus.addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage-1 read data: no-change mode suppresses the result of any write
  always_comb begin
    rd1_d = rd1_q;
    v1_d  = 1'b0;
    if (acc_c && !((RD_MODE == 2) && (|bus.we_a))) begin
      v1_d  = 1'b1;
      rd1_d = (RD_MODE == 1) ? merged_c : old_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd1_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      v1_q  <= v1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd2_q;
      logic                  v2_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd2_q <= '0;
          v2_q  <= 1'b0;
        end else begin
          rd2_q <= rd1_q;
          v2_q  <= v1_q;
        end
      end
      assign bus.dout_a       = rd2_q;
      assign bus.dout_valid_a = v2_q;
    end else begin : g_noreg
      assign bus.dout_a       = rd1_q;
      assign bus.dout_valid_a = v1_q;
    end
  endgenerate

  assign bus.busy = busy_q;
endmodule
